// File: rtl/wptr_full_if.sv
// Write-side bundle of the dual-clock FIFO: producer requests, synchronized read
// pointer, and the pointer/flag outputs of wptr_full.
interface wptr_full_if #(
  parameter int ADDR_LINES = 8
);
  logic                  winc;
  logic [ADDR_LINES:0]   wq2_rptr;
  logic                  wclr_ovf;
  logic                  wen;
  logic [ADDR_LINES-1:0] waddr;
  logic [ADDR_LINES:0]   wptr;
  logic                  wfull;
  logic                  walmost_full;
  logic [ADDR_LINES:0]   wlevel;
  logic                  woverflow;

  modport master (
    output winc, wq2_rptr, wclr_ovf,
    input  wen, waddr, wptr, wfull, walmost_full, wlevel, woverflow
  );

  modport slave (
    input  winc, wq2_rptr, wclr_ovf,
    output wen, waddr, wptr, wfull, walmost_full, wlevel, woverflow
  );
endinterface

// File: rtl/wptr_full.sv
// Write pointer, full flag and sticky overflow for the dual-clock FIFO.
// Define WPTR_LEVEL_EN to build the fill level and threshold-based almost-full flag.
module wptr_full #(
  parameter int ADDR_LINES   = 8,
  parameter int AFULL_THRESH = 240
) (
  input  logic       wclk,
  input  logic       wrst,
  wptr_full_if.slave bus
);

  logic [ADDR_LINES:0] r_wbin;
  logic [ADDR_LINES:0] r_wptr;
  logic                r_wfull;
  logic                r_woverflow;

  logic                w_wen;
  logic [ADDR_LINES:0] w_wbinnext;
  logic [ADDR_LINES:0] w_wgraynext;
  logic                w_wfull_val;

  assign w_wen       = bus.winc & ~r_wfull;
  assign w_wbinnext  = r_wbin + {{ADDR_LINES{1'b0}}, w_wen};
  assign w_wgraynext = (w_wbinnext >> 1) ^ w_wbinnext;

  // Full when the writer is exactly one lap ahead: top two Gray bits inverted.
  assign w_wfull_val = (w_wgraynext ==
                        {~bus.wq2_rptr[ADDR_LINES:ADDR_LINES-1], bus.wq2_rptr[ADDR_LINES-2:0]});

  // NOTE: async reset in the sensitivity list so outputs clear without a clock edge;
  // state is updated with non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      r_wbin      <= '0;
      r_wptr      <= '0;
      r_wfull     <= 1'b0;
      r_woverflow <= 1'b0;
    end else begin
      r_wbin      <= w_wbinnext;
      r_wptr      <= w_wgraynext;
      r_wfull     <= w_wfull_val;
      r_woverflow <= (bus.winc & r_wfull) | (r_woverflow & ~bus.wclr_ovf);
    end
  end

`ifdef WPTR_LEVEL_EN
  localparam logic [ADDR_LINES:0] AFULL_W = AFULL_THRESH[ADDR_LINES:0];

  logic [ADDR_LINES:0] w_rbin_s;
  logic [ADDR_LINES:0] w_diff;
  logic [ADDR_LINES:0] r_wlevel;
  logic                r_walmost_full;

  // NOTE: every bit gets a default before the loop so no latch is inferred.
  always_comb begin
    w_rbin_s             = '0;
    w_rbin_s[ADDR_LINES] = bus.wq2_rptr[ADDR_LINES];
    for (int i = ADDR_LINES - 1; i >= 0; i--) begin
      w_rbin_s[i] = w_rbin_s[i+1] ^ bus.wq2_rptr[i];
    end
  end

  assign w_diff = w_wbinnext - w_rbin_s;

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      r_wlevel       <= '0;
      r_walmost_full <= 1'b0;
    end else begin
      r_wlevel       <= w_diff;
      r_walmost_full <= (w_diff >= AFULL_W);
    end
  end

  assign bus.wlevel       = r_wlevel;
  assign bus.walmost_full = r_walmost_full;
`else
  assign bus.wlevel       = '0;
  assign bus.walmost_full = r_wfull;
`endif

  assign bus.wen       = w_wen;
  assign bus.waddr     = r_wbin[ADDR_LINES-1:0];
  assign bus.wptr      = r_wptr;
  assign bus.wfull     = r_wfull;
  assign bus.woverflow = r_woverflow;

endmodule

// File: tb/tb_wptr_full.sv
// Self-checking bench for wptr_full: directed fill/overflow/drain/reset steps plus
// random traffic, checked against an occupancy-count model of the FIFO.
module tb_wptr_full;

  localparam int AL    = 8;
  localparam int DEPTH = 1 << AL;
  localparam int MOD   = 2 * DEPTH;
  localparam int THR   = 240;

  logic wclk = 1'b0;
  logic wrst = 1'b1;
  always #5 wclk = ~wclk;

  wptr_full_if #(.ADDR_LINES(AL)) bus ();

  wptr_full #(.ADDR_LINES(AL), .AFULL_THRESH(THR)) dut (
    .wclk (wclk),
    .wrst (wrst),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: write count and read count modulo 2*DEPTH.
  int m_wbin = 0;
  int rbin   = 0;
  int m_lvl  = 0;
  bit m_full = 1'b0;
  bit m_ovf  = 1'b0;

  function automatic int gray(input int b);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    bit af;
`ifdef WPTR_LEVEL_EN
    af = (m_lvl >= THR);
    check("wlevel", 32'(bus.wlevel), 32'(m_lvl));
`else
    af = m_full;
    check("wlevel_off", 32'(bus.wlevel), 32'd0);
`endif
    check("wptr", 32'(bus.wptr), 32'(gray(m_wbin)));
    check("waddr", 32'(bus.waddr), 32'(m_wbin % DEPTH));
    check("wfull", 32'(bus.wfull), 32'(m_full));
    check("walmost_full", 32'(bus.walmost_full), 32'(af));
    check("woverflow", 32'(bus.woverflow), 32'(m_ovf));
  endtask

  task automatic model_reset();
    m_wbin = 0; m_lvl = 0; m_full = 1'b0; m_ovf = 1'b0; rbin = 0;
  endtask

  // One write-clock cycle: drive, check the RAM enable, clock, update model, check.
  task automatic cycle(input bit w, input bit c);
    bit acc;
    int d;
    bus.winc     = w;
    bus.wclr_ovf = c;
    bus.wq2_rptr = 9'(gray(rbin));
    #1;
    check("wen", 32'(bus.wen), 32'(w && !m_full));
    @(posedge wclk);
    acc    = w && !m_full;
    m_ovf  = (w && m_full) || (m_ovf && !c);
    m_wbin = (m_wbin + int'(acc)) % MOD;
    d      = (m_wbin - rbin + MOD) % MOD;
    m_full = (d == DEPTH);
    m_lvl  = d;
    #1;
    check_all();
  endtask

  initial begin
    bus.winc = 1'b0; bus.wclr_ovf = 1'b0; bus.wq2_rptr = '0;
    #3;
    check_all();
    @(negedge wclk);
    wrst = 1'b0;

    // Fill from empty.
    for (int i = 1; i <= DEPTH; i++) begin
      cycle(1'b1, 1'b0);
`ifdef WPTR_LEVEL_EN
      if (i == THR - 1) begin
        check("af_239_lvl", 32'(bus.wlevel), 32'd239);
        check("af_239_flag", 32'(bus.walmost_full), 32'd0);
      end
      if (i == THR) begin
        check("af_240_lvl", 32'(bus.wlevel), 32'd240);
        check("af_240_flag", 32'(bus.walmost_full), 32'd1);
      end
      if (i == DEPTH) check("fill_lvl", 32'(bus.wlevel), 32'd256);
`endif
      if (i == DEPTH - 1) check("fill_not_full", 32'(bus.wfull), 32'd0);
      if (i == DEPTH) begin
        check("fill_full", 32'(bus.wfull), 32'd1);
        check("fill_wptr", 32'(bus.wptr), 32'h180);
        check("fill_waddr", 32'(bus.waddr), 32'd0);
      end
    end

    // Overflow: write while full, then clear with and without a concurrent overflow.
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    check("ovf_set", 32'(bus.woverflow), 32'd1);
    check("ovf_wptr", 32'(bus.wptr), 32'h180);
    check("ovf_waddr", 32'(bus.waddr), 32'd0);
    cycle(1'b1, 1'b1);
    check("ovf_set_wins", 32'(bus.woverflow), 32'd1);
    cycle(1'b0, 1'b1);
    check("ovf_cleared", 32'(bus.woverflow), 32'd0);

    // Drain and refill across the pointer wrap.
    rbin = DEPTH;
    cycle(1'b0, 1'b0);
    check("drain_full", 32'(bus.wfull), 32'd0);
    for (int i = 1; i <= DEPTH; i++) begin
      cycle(1'b1, 1'b0);
      if (i == DEPTH - 1) begin
        check("wrap_wptr_pre", 32'(bus.wptr), 32'h100);
        check("wrap_not_full", 32'(bus.wfull), 32'd0);
      end
      if (i == DEPTH) begin
        check("wrap_wptr", 32'(bus.wptr), 32'h000);
        check("wrap_full", 32'(bus.wfull), 32'd1);
      end
    end

    // Random traffic; the reader never passes the writer.
    for (int i = 0; i < 600; i++) begin
      if (((m_wbin - rbin + MOD) % MOD) > 0 && ($urandom % 2) == 0)
        rbin = (rbin + 1) % MOD;
      cycle(1'($urandom % 4 != 0), 1'($urandom % 8 == 0));
    end

    // Reset mid-operation.
    #2; wrst = 1'b1;
    @(negedge wclk);
    wrst = 1'b0;
    model_reset();
    for (int i = 0; i < 100; i++) cycle(1'b1, 1'b0);
    #2; wrst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge wclk);
    wrst = 1'b0;
    check("post_rst_waddr", 32'(bus.waddr), 32'd0);
    cycle(1'b1, 1'b0);
    check("post_rst_write", 32'(bus.waddr), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wptr_full.md
# wptr_full

Write-side pointer and full-flag generator for the dual-clock FIFO. It runs in the write clock domain and accepts write requests from the producer. It advances a binary/Gray write pointer, drives the RAM write address, and compares against the read pointer synchronized into `wclk` to produce `wfull`. It also provides an optional fill level, an almost-full flag and a sticky overflow error. It is the write-domain counterpart of the read-pointer/empty block and feeds `wptr` to the write-to-read synchronizer.

## Interface
Parameters:
- `ADDR_LINES`, 8, RAM address width; FIFO depth is 2^ADDR_LINES.
- `AFULL_THRESH`, 240, level at or above which `walmost_full` asserts. Legal range is 1..2^ADDR_LINES.

Ports:
- `wclk`  in  1  write clock; the only clock in this block.
- `wrst`  in  1  reset, asynchronous, active-high.
- `winc`  in  1  write request; a write is accepted only when `wfull`=0.
- `wq2_rptr`  in  ADDR_LINES+1  Gray read pointer, already 2-flop synchronized into `wclk`.
- `wclr_ovf`  in  1  clears `woverflow`.
- `waddr`  out  ADDR_LINES  RAM write address.
- `wptr`  out  ADDR_LINES+1  registered Gray write pointer, sent to the synchronizer.
- `wfull`  out  1  FIFO full.
- `walmost_full`  out  1  level >= AFULL_THRESH.
- `wlevel`  out  ADDR_LINES+1  entries held, as seen from the write side.
- `woverflow`  out  1  sticky: a write was attempted while full.

## Operation
- Internal register `wbin` is ADDR_LINES+1 bits wide.
  - `wbinnext = wbin + (winc & ~wfull)`, modulo 2^(ADDR_LINES+1).
  - `wgraynext = (wbinnext>>1) ^ wbinnext`.
  - `wbin` and `wptr` load `wbinnext` and `wgraynext` on the same edge.
- `waddr = wbin[ADDR_LINES-1:0]`, driven combinationally from the register. The RAM writes at `waddr` when `winc & ~wfull`.
- Full condition:
  - `wfull_val = (wgraynext == {~wq2_rptr[ADDR_LINES:ADDR_LINES-1], wq2_rptr[ADDR_LINES-2:0]})`.
  - `wfull` is registered from `wfull_val`.
- Level:
  - `rbin_s` is the Gray-to-binary conversion of `wq2_rptr`, using a combinational XOR prefix from the MSB down.
  - `wlevel` is registered from `wbinnext - rbin_s` (ADDR_LINES+1 bits, modulo). Its range is 0..2^ADDR_LINES.
  - `walmost_full` is registered from `(wbinnext - rbin_s) >= AFULL_THRESH`.
- Overflow:
  - `woverflow` sets on any edge where `winc & wfull`.
  - It clears on `wclr_ovf`.
  - If set and clear occur in the same cycle, set wins.
- Write while full: the pointer and address are unchanged, and no RAM write enable is issued.
- Wrap-around: `wbin` goes from 2^(ADDR_LINES+1)-1 to 0. In Gray code only the MSB changes; the full compare handles this by construction.
- Reset (`wrst`=1, asynchronous):
  - `wbin`=0, `wptr`=0, `waddr`=0, `wfull`=0, `wlevel`=0, `walmost_full`=0, `woverflow`=0.
  - Outputs take these values immediately, without waiting for a clock edge.
  - Reset asserted mid-operation discards all state. The synchronizer and read side are reset by the system at the same time.

## Timing
- All flags and pointers are registered and update on the `wclk` edge that samples `winc`. There are no combinational paths from `winc` to any output except the RAM enable.
- `wfull` rises on the same edge that accepts the write filling the last slot. A write in the following cycle is refused.
- A read-side pop reaches `wq2_rptr` after 2 `wclk` edges (external synchronizer). `wfull`, `wlevel` and `walmost_full` reflect the pop 1 edge later, so 3 edges total.
- Flags are pessimistic. `wfull` may remain asserted after a pop, but must never deassert while the FIFO is actually full. `wlevel` may over-report and never under-reports.
- `wclr_ovf` takes effect on the next edge. `woverflow` reads 0 one cycle later unless a new overflow occurs.

## Configuration
- Macro: `WPTR_LEVEL_EN`.
- Defined: `wlevel` and `walmost_full` behave as described above, including Gray-to-binary conversion and the subtractor.
- Undefined:
  - The conversion and subtractor are not built.
  - `wlevel` is tied to 0.
  - `walmost_full` equals `wfull`.
  - `AFULL_THRESH` is ignored.
- `wptr`, `waddr`, `wfull` and `woverflow` are identical in both builds.

## Test plan
All scenarios use `ADDR_LINES`=8 (depth 256).
- Fill: hold `wq2_rptr`=0 and issue 256 consecutive `winc`.
  - `wfull` rises on the 256th accepting edge.
  - Then `wptr`=9'h180, `waddr`=0, `wlevel`=256.
- Almost-full (macro defined): with `wq2_rptr`=0, issue 239 writes, then 1 more.
  - After 239 writes, `walmost_full`=0 and `wlevel`=239.
  - After the 240th write, `walmost_full`=1 and `wlevel`=240.
- Overflow: with the FIFO full, assert `winc` for 2 cycles.
  - `waddr` stays 0 and `wptr` stays 9'h180; `woverflow`=1.
  - Then assert `wclr_ovf` together with `winc` (still full): `woverflow` stays 1.
  - Then assert `wclr_ovf` alone: `woverflow`=0.
- Drain/wrap: from full, drive `wq2_rptr`=9'h180 (256 reads).
  - `wfull`=0 and `wlevel`=0 one edge later.
  - Write 256 more: `wbin` wraps 511→0, `wptr` goes 9'h100→9'h000, and `wfull` rises on the 256th write.
- Reset mid-op: after 100 writes, assert `wrst` between clock edges.
  - All outputs read 0 before the next `wclk` edge.
  - After deassertion, the first write uses `waddr`=0.
- Macro off: repeat the fill scenario.
  - `wlevel`=0 throughout.
  - `walmost_full` tracks `wfull` exactly.
